// File: rtl/urna_pkg.sv
// Shared types and constants for the voting-session controller: state codes,
// counter-select codes and default candidate numbers.
package urna_pkg;

  // State codes double as the LCD page code and the HEX0 phase value.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ENTRY   = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_LOCK    = 3'd3,
    ST_SCAN    = 3'd4,
    ST_RESULT  = 3'd5,
    ST_TOTAL1  = 3'd6,
    ST_TOTAL2  = 3'd7
  } state_t;

  localparam int NUM_CAND = 4;
  localparam int NUM_CNT  = 6;

  localparam logic [2:0] SEL_CAND1 = 3'd0;
  localparam logic [2:0] SEL_CAND2 = 3'd1;
  localparam logic [2:0] SEL_CAND3 = 3'd2;
  localparam logic [2:0] SEL_CAND4 = 3'd3;
  localparam logic [2:0] SEL_NULL  = 3'd4;
  localparam logic [2:0] SEL_TOTAL = 3'd5;

  localparam logic [3:0] TIE_DIGIT = 4'd8;

  localparam logic [7:0] DEF_CAND1 = 8'h12;
  localparam logic [7:0] DEF_CAND2 = 8'h13;
  localparam logic [7:0] DEF_CAND3 = 8'h17;
  localparam logic [7:0] DEF_CAND4 = 8'h51;

  function automatic logic [7:0] bcd_pair(input logic [3:0] tens, input logic [3:0] units);
    return {tens, units};
  endfunction

endpackage

// File: rtl/urna_lock_timer.sv
// Loadable down-counter that raises a one-cycle done pulse when it has run
// for load_val+1 cycles after a load.
module urna_lock_timer #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count_q;
  logic         active_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q  <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      count_q  <= load_val;
      active_q <= 1'b1;
    end else if (active_q) begin
      if (count_q == '0) active_q <= 1'b0;
      else               count_q  <= count_q - W'(1);
    end
  end

  assign done = active_q && (count_q == '0);

endmodule

// File: rtl/urna_vote_ctrl.sv
// Single-clock voting-session controller: digit entry, confirmation, tally
// commit, post-vote lockout, sequential winner scan and LCD page requests.
module urna_vote_ctrl
  import urna_pkg::*;
#(
  parameter logic [7:0]  CAND1       = DEF_CAND1,
  parameter logic [7:0]  CAND2       = DEF_CAND2,
  parameter logic [7:0]  CAND3       = DEF_CAND3,
  parameter logic [7:0]  CAND4       = DEF_CAND4,
  parameter int unsigned LOCK_CYCLES = 25000000,
  parameter int          CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_next,
  input  logic             key_cancel,
  input  logic             chave,
  input  logic [3:0]       dig_tens,
  input  logic [3:0]       dig_units,
  output logic             lcd_req,
  output logic [2:0]       lcd_page,
  input  logic             lcd_ack,
  output logic [3:0]       phase,
  output logic             buzzer,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [3:0]       win_tens,
  output logic [3:0]       win_units
);

  localparam int                TMR_W     = $clog2(LOCK_CYCLES + 1);
  localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  state_t           state_q, state_d;
  logic             reenter, commit, enter;
  logic             next_p, cancel_p;
  logic             lock_done;
  logic [2:0]       vote_sel;
  logic [7:0]       cand_num [NUM_CAND];
  logic [CNT_W-1:0] cnt_q    [NUM_CNT];

  logic [1:0]       scan_idx_q;
  logic [CNT_W-1:0] max_q, max_d, scan_cnt;
  logic             tie_q, tie_d;
  logic [1:0]       win_idx_q, win_idx_d;

  assign cand_num[0] = CAND1;
  assign cand_num[1] = CAND2;
  assign cand_num[2] = CAND3;
  assign cand_num[3] = CAND4;

  // Keys only count while the LCD writer is idle; cancel beats next.
  assign cancel_p = key_cancel && !lcd_req;
  assign next_p   = key_next && !key_cancel && !lcd_req;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    reenter = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE:    if (next_p) state_d = chave ? ST_SCAN : ST_ENTRY;
      ST_ENTRY: begin
        if (cancel_p)    reenter = 1'b1;
        else if (next_p) state_d = ST_CONFIRM;
      end
      ST_CONFIRM: begin
        if (cancel_p) state_d = ST_ENTRY;
        else if (next_p) begin
          state_d = ST_LOCK;
          commit  = 1'b1;
        end
      end
      ST_LOCK:    if (lock_done) state_d = ST_IDLE;
      ST_SCAN:    if (scan_idx_q == 2'd3) state_d = ST_RESULT;
      ST_RESULT:  if (next_p) state_d = ST_TOTAL1;
      ST_TOTAL1:  if (next_p) state_d = ST_TOTAL2;
      ST_TOTAL2:  if (next_p) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  assign enter = (state_d != state_q) || reenter;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign phase  = {1'b0, state_q};
  assign buzzer = (state_q == ST_LOCK);

  // A new entry overrides a pending request; ack only clears an idle-free request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lcd_req  <= 1'b0;
      lcd_page <= 3'd0;
    end else if (enter) begin
      lcd_req  <= 1'b1;
      lcd_page <= state_d;
    end else if (lcd_ack) begin
      lcd_req  <= 1'b0;
    end
  end

  urna_lock_timer #(.W(TMR_W)) u_lock_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (commit),
    .load_val (LOCK_LOAD),
    .done     (lock_done)
  );

  // Lowest-numbered matching candidate wins; no match goes to the null counter.
  always_comb begin
    vote_sel = SEL_NULL;
    for (int i = NUM_CAND - 1; i >= 0; i--) begin
      if (bcd_pair(dig_tens, dig_units) == cand_num[i]) vote_sel = 3'(i);
    end
  end

  // NOTE: the counter array is a handful of flops that must read zero right
  // after reset, so it is reset explicitly rather than left as an unreset RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
    end else if (commit) begin
      if (cnt_q[vote_sel] != CNT_MAX)  cnt_q[vote_sel]  <= cnt_q[vote_sel] + CNT_W'(1);
      if (cnt_q[SEL_TOTAL] != CNT_MAX) cnt_q[SEL_TOTAL] <= cnt_q[SEL_TOTAL] + CNT_W'(1);
    end
  end

  always_comb begin
    rd_cnt = '0;
    if (rd_sel <= SEL_TOTAL) rd_cnt = cnt_q[rd_sel];
  end

  always_comb begin
    scan_cnt  = cnt_q[{1'b0, scan_idx_q}];
    max_d     = max_q;
    tie_d     = tie_q;
    win_idx_d = win_idx_q;
    if (scan_cnt > max_q) begin
      max_d     = scan_cnt;
      win_idx_d = scan_idx_q;
      tie_d     = 1'b0;
    end else if ((scan_cnt == max_q) && (scan_cnt != '0)) begin
      tie_d     = 1'b1;
    end
  end

  // One candidate per SCAN cycle; the winner digits land with the last step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_idx_q <= 2'd0;
      max_q      <= '0;
      tie_q      <= 1'b0;
      win_idx_q  <= 2'd0;
      win_tens   <= TIE_DIGIT;
      win_units  <= TIE_DIGIT;
    end else if ((state_d == ST_SCAN) && (state_q != ST_SCAN)) begin
      scan_idx_q <= 2'd0;
      max_q      <= '0;
      tie_q      <= 1'b0;
      win_idx_q  <= 2'd0;
    end else if (state_q == ST_SCAN) begin
      scan_idx_q <= scan_idx_q + 2'd1;
      max_q      <= max_d;
      tie_q      <= tie_d;
      win_idx_q  <= win_idx_d;
      if (scan_idx_q == 2'd3) begin
        if (tie_d || (max_d == '0)) begin
          win_tens  <= TIE_DIGIT;
          win_units <= TIE_DIGIT;
        end else begin
          win_tens  <= cand_num[win_idx_d][7:4];
          win_units <= cand_num[win_idx_d][3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_urna_vote_ctrl.sv
// Directed bench for urna_vote_ctrl: voting, cancel, scan/winner, handshake,
// asynchronous reset and counter saturation, with hand-computed expectations.
module tb_urna_vote_ctrl;

  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             key_next = 1'b0, key_cancel = 1'b0, chave = 1'b0;
  logic [3:0]       dig_tens = 4'd0, dig_units = 4'd0;
  logic             lcd_req, lcd_ack = 1'b0;
  logic [2:0]       lcd_page;
  logic [3:0]       phase;
  logic             buzzer;
  logic [2:0]       rd_sel = 3'd0;
  logic [CNT_W-1:0] rd_cnt;
  logic [3:0]       win_tens, win_units;

  int n_cmp = 0;
  int n_err = 0;

  urna_vote_ctrl #(.LOCK_CYCLES(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .key_next(key_next), .key_cancel(key_cancel),
    .chave(chave), .dig_tens(dig_tens), .dig_units(dig_units),
    .lcd_req(lcd_req), .lcd_page(lcd_page), .lcd_ack(lcd_ack),
    .phase(phase), .buzzer(buzzer), .rd_sel(rd_sel), .rd_cnt(rd_cnt),
    .win_tens(win_tens), .win_units(win_units)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_next();
    key_next = 1'b1; tick(1); key_next = 1'b0;
  endtask

  task automatic pulse_cancel();
    key_cancel = 1'b1; tick(1); key_cancel = 1'b0;
  endtask

  task automatic read_cnt(input string tag, input logic [2:0] sel, input int exp);
    rd_sel = sel; #1;
    check(tag, 32'(rd_cnt), exp);
  endtask

  // Wait (bounded) for a page request, check its page, then acknowledge it.
  task automatic ack_page(input string tag, input int pg);
    int n = 0;
    while (lcd_req !== 1'b1 && n < 100) begin tick(1); n++; end
    check({tag, "_req"}, 32'(lcd_req), 1);
    check({tag, "_page"}, 32'(lcd_page), pg);
    lcd_ack = 1'b1; tick(1); lcd_ack = 1'b0;
    check({tag, "_drop"}, 32'(lcd_req), 0);
  endtask

  task automatic cast(input logic [3:0] t, input logic [3:0] u);
    chave = 1'b0;
    pulse_next();  ack_page("cast_entry", 1);
    dig_tens = t; dig_units = u;
    pulse_next();  ack_page("cast_confirm", 2);
    pulse_next();  ack_page("cast_lock", 3);
    ack_page("cast_idle", 0);
  endtask

  task automatic scan_and_exit(input string tag, input int wt, input int wu);
    chave = 1'b1;
    pulse_next();  ack_page({tag, "_scan"}, 4);
    ack_page({tag, "_result"}, 5);
    check({tag, "_win_tens"}, 32'(win_tens), wt);
    check({tag, "_win_units"}, 32'(win_units), wu);
    chave = 1'b0;
    pulse_next();  ack_page({tag, "_t1"}, 6);
    pulse_next();  ack_page({tag, "_t2"}, 7);
    pulse_next();  ack_page({tag, "_idle"}, 0);
  endtask

  task automatic apply_reset();
    reset = 1'b0; tick(2); reset = 1'b1; tick(1);
  endtask

  initial begin
    int hi;

    // Reset state
    tick(2);
    check("rst_phase", 32'(phase), 0);
    check("rst_buzzer", 32'(buzzer), 0);
    check("rst_req", 32'(lcd_req), 0);
    check("rst_page", 32'(lcd_page), 0);
    check("rst_win_tens", 32'(win_tens), 8);
    check("rst_win_units", 32'(win_units), 8);
    for (int i = 0; i < 6; i++) read_cnt("rst_cnt", 3'(i), 0);
    reset = 1'b1; tick(1);

    // Vote 1,2 with lockout length measured on the buzzer
    pulse_next();  ack_page("v12_entry", 1);
    dig_tens = 4'd1; dig_units = 4'd2;
    pulse_next();  ack_page("v12_confirm", 2);
    pulse_next();
    check("v12_phase_lock", 32'(phase), 3);
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (buzzer === 1'b1) hi++;
    end
    tick(1);
    check("v12_buzzer_cycles", hi, 16);
    check("v12_phase_idle", 32'(phase), 0);
    ack_page("v12_idle", 0);
    read_cnt("v12_cand1", 3'd0, 1);
    read_cnt("v12_total", 3'd5, 1);
    read_cnt("v12_null", 3'd4, 0);

    // Cancel path, simultaneous keys, and pre-commit read in the commit cycle
    apply_reset();
    pulse_next();  ack_page("can_entry", 1);
    dig_tens = 4'd9; dig_units = 4'd9;
    pulse_next();  ack_page("can_confirm", 2);
    pulse_cancel(); ack_page("can_back", 1);
    check("can_phase", 32'(phase), 1);
    read_cnt("can_total0", 3'd5, 0);
    read_cnt("can_null0", 3'd4, 0);
    pulse_next();  ack_page("can_confirm2", 2);
    key_next = 1'b1; key_cancel = 1'b1; tick(1); key_next = 1'b0; key_cancel = 1'b0;
    ack_page("both_back", 1);
    check("both_phase", 32'(phase), 1);
    read_cnt("both_total", 3'd5, 0);
    pulse_next();  ack_page("can_confirm3", 2);
    rd_sel = 3'd5; key_next = 1'b1; #1;
    check("commit_cycle_pre", 32'(rd_cnt), 0);
    tick(1); key_next = 1'b0;
    check("commit_cycle_post", 32'(rd_cnt), 1);
    ack_page("can_lock", 3);
    ack_page("can_idle", 0);
    read_cnt("can_null", 3'd4, 1);
    read_cnt("can_total", 3'd5, 1);
    read_cnt("can_cand1", 3'd0, 0);

    // Tally and scan: 3x13, 2x51, 1x12 -> winner 13
    apply_reset();
    cast(4'd1, 4'd3); cast(4'd1, 4'd3); cast(4'd1, 4'd3);
    cast(4'd5, 4'd1); cast(4'd5, 4'd1); cast(4'd1, 4'd2);
    read_cnt("tal_c1", 3'd0, 1);
    read_cnt("tal_c2", 3'd1, 3);
    read_cnt("tal_c3", 3'd2, 0);
    read_cnt("tal_c4", 3'd3, 2);
    read_cnt("tal_total", 3'd5, 6);
    chave = 1'b1;
    pulse_next();
    check("scan_phase", 32'(phase), 4);
    check("scan_page", 32'(lcd_page), 4);
    tick(3);
    check("scan_phase_3", 32'(phase), 4);
    check("scan_win_early", 32'(win_tens), 8);
    tick(1);
    check("scan_phase_4", 32'(phase), 5);
    check("scan_win_tens", 32'(win_tens), 1);
    check("scan_win_units", 32'(win_units), 3);
    ack_page("scan_result", 5);
    chave = 1'b0;
    pulse_next();  ack_page("scan_t1", 6);
    pulse_next();  ack_page("scan_t2", 7);
    pulse_next();  ack_page("scan_idle", 0);

    // Tie: add 2x17, 1x51 -> counts 1,3,2,3 -> 8/8
    cast(4'd1, 4'd7); cast(4'd1, 4'd7); cast(4'd5, 4'd1);
    scan_and_exit("tie", 8, 8);

    // Tie cleared by a later larger count: 12,13,17,17 -> 17
    apply_reset();
    cast(4'd1, 4'd2); cast(4'd1, 4'd3); cast(4'd1, 4'd7); cast(4'd1, 4'd7);
    scan_and_exit("untie", 1, 7);

    // No votes at all
    apply_reset();
    scan_and_exit("novote", 8, 8);

    // Handshake: withheld ack blocks keys
    apply_reset();
    pulse_next();
    check("hs_req", 32'(lcd_req), 1);
    pulse_next();
    tick(8);
    check("hs_req_held", 32'(lcd_req), 1);
    check("hs_phase_held", 32'(phase), 1);
    lcd_ack = 1'b1; #1;
    check("hs_req_ack_cycle", 32'(lcd_req), 1);
    tick(1); lcd_ack = 1'b0;
    check("hs_req_dropped", 32'(lcd_req), 0);
    lcd_ack = 1'b1; tick(1); lcd_ack = 1'b0;
    check("hs_stray_req", 32'(lcd_req), 0);
    check("hs_stray_phase", 32'(phase), 1);
    pulse_next();  ack_page("hs_confirm", 2);

    // Reset mid-LOCK
    apply_reset();
    pulse_next();  ack_page("rl_entry", 1);
    dig_tens = 4'd1; dig_units = 4'd2;
    pulse_next();  ack_page("rl_confirm", 2);
    pulse_next();
    tick(5);
    check("rl_buzzer_on", 32'(buzzer), 1);
    read_cnt("rl_total_pre", 3'd5, 1);
    #2 reset = 1'b0; #1;
    check("rl_phase", 32'(phase), 0);
    check("rl_buzzer", 32'(buzzer), 0);
    check("rl_req", 32'(lcd_req), 0);
    read_cnt("rl_total", 3'd5, 0);
    read_cnt("rl_cand1", 3'd0, 0);
    tick(1); reset = 1'b1;
    tick(20);
    check("rl_phase_after", 32'(phase), 0);
    check("rl_req_after", 32'(lcd_req), 0);

    // Reset mid-SCAN
    cast(4'd1, 4'd3);
    chave = 1'b1;
    pulse_next();
    tick(1);
    check("rs_phase_scan", 32'(phase), 4);
    #2 reset = 1'b0; #1;
    check("rs_phase", 32'(phase), 0);
    check("rs_req", 32'(lcd_req), 0);
    check("rs_win_tens", 32'(win_tens), 8);
    read_cnt("rs_cand2", 3'd1, 0);
    tick(1); reset = 1'b1; chave = 1'b0;
    tick(6);
    check("rs_phase_after", 32'(phase), 0);
    check("rs_win_after", 32'(win_units), 8);

    // Saturation: 70 votes for 13
    apply_reset();
    for (int i = 0; i < 70; i++) cast(4'd1, 4'd3);
    read_cnt("sat_cand2", 3'd1, 63);
    read_cnt("sat_total", 3'd5, 63);
    read_cnt("sat_null", 3'd4, 0);
    read_cnt("sat_cand1", 3'd0, 0);
    read_cnt("sat_sel6", 3'd6, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/urna_vote_ctrl.md
Name: urna_vote_ctrl

Overview:
- Synchronous controller that sequences one voting session: digit entry, confirmation, tally commit, post-vote lockout, then apuration (sequential winner scan and total pages).
- Sits between the key debouncers and digit module on one side, and the LCD content/writer on the other.
- Owns all vote counters and exposes them through a select/read port.
- Replaces the key-edge-clocked state and counter logic with a single-clock design.

Parameters:
- CAND1, 12, BCD-encoded number of candidate 1 (tens 1, units 2)
- CAND2, 13, candidate 2 number
- CAND3, 17, candidate 3 number
- CAND4, 51, candidate 4 number
- LOCK_CYCLES, 25000000, post-vote lockout length in clk cycles (0.5 s at 50 MHz)
- CNT_W, 6, width of every vote counter

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-low
- key_next  in  1  one-cycle pulse, debounced "advance/confirm" key
- key_cancel  in  1  one-cycle pulse, debounced "correct" key
- chave  in  1  mode switch; 0 = voting, 1 = apuration
- dig_tens  in  4  BCD tens digit from the digit module
- dig_units  in  4  BCD units digit
- lcd_req  out  1  page-change request to the LCD writer
- lcd_page  out  3  page code; valid while lcd_req=1
- lcd_ack  in  1  one-cycle pulse that completes the request
- phase  out  4  current state code, for the 7-seg HEX0
- buzzer  out  1  high during lockout
- rd_sel  in  3  counter select: 0-3 = candidates, 4 = null, 5 = total
- rd_cnt  out  CNT_W  selected counter, combinational from rd_sel
- win_tens  out  4  winner tens digit; 8 on tie or no votes
- win_units  out  4  winner units digit

Behaviour:
- Reset (async, active-low): all outputs and state are cleared immediately.
  - state = IDLE; all counters = 0; win_tens = win_units = 8; buzzer = 0; lcd_req = 0; lcd_page = 0; phase = 0.
- States, with codes used for phase and lcd_page:
  - IDLE = 0, ENTRY = 1, CONFIRM = 2, LOCK = 3, SCAN = 4, RESULT = 5, TOTAL1 = 6, TOTAL2 = 7.
- Transitions, taken only on key pulses accepted while lcd_req = 0:
  - IDLE: key_next with chave = 0 -> ENTRY; with chave = 1 -> SCAN.
  - ENTRY: key_next -> CONFIRM; key_cancel -> ENTRY (re-requests page 1).
  - CONFIRM: key_next -> commit, then LOCK; key_cancel -> ENTRY with no commit.
  - LOCK: timer counts LOCK_CYCLES, then -> IDLE automatically. Keys are ignored. buzzer = 1 for the whole state.
  - SCAN: no key needed; runs 4 cycles (one candidate per cycle), then -> RESULT.
  - RESULT -> TOTAL1 -> TOTAL2 -> IDLE, each on key_next.
- Commit (single cycle, on the CONFIRM->LOCK edge):
  - {dig_tens, dig_units} matching CANDn increments counter n; no match increments null.
  - total increments in every case.
  - All counters saturate at 2^CNT_W-1; total saturation does not block the candidate or null increment.
- SCAN:
  - Running max starts at 0.
  - Strictly greater count: updates max and the winner and clears the tie flag.
  - Equal nonzero count: sets the tie flag.
  - At the end: tie or max = 0 -> win = 8/8; otherwise win = the candidate's BCD digits.
  - win outputs update in the last scan cycle.
- LCD handshake:
  - Every state entry asserts lcd_req with lcd_page = the new state code in the next cycle.
  - lcd_req holds until lcd_ack, then clears in the cycle after ack.
  - An ack arriving while lcd_req = 0 is ignored.
  - LOCK and SCAN timers/steps run regardless of lcd_req.
  - If a new state is entered while a request is pending, lcd_page updates and lcd_req stays high.
- Simultaneous pulses: key_next and key_cancel in the same cycle -> key_cancel wins.
- chave is sampled only in IDLE.
- rd_cnt reads the pre-commit value in the commit cycle.

Decomposition:
- Package urna_pkg holds:
  - state enum and codes;
  - counter-select codes;
  - the TIE_DIGIT = 8 constant;
  - default candidate numbers.
- One sub-module, urna_lock_timer: loadable down-counter with a done pulse, used for LOCK.

Test Plan:
- Vote 1,2: IDLE, next, next, next with digits 1/2 -> cand1 = 1, total = 1, null = 0; buzzer high exactly LOCK_CYCLES cycles (use LOCK_CYCLES = 16), then phase = 0.
- Cancel path: in CONFIRM pulse key_cancel -> phase = 1, no counter change; then confirm digits 9/9 -> null = 1, total = 1.
- Tally and scan: cast 3x 13, 2x 51, 1x 12, then chave = 1 and next -> after 4 cycles win = 1/3; RESULT page requested.
- Tie: 2x 17 and 2x 51 -> win = 8/8; with no votes at all -> win = 8/8.
- Handshake: withhold lcd_ack for 10 cycles -> lcd_req stays 1, key_next ignored, phase unchanged; ack -> lcd_req drops the next cycle.
- Reset mid-LOCK and mid-SCAN -> immediately phase = 0, buzzer = 0, counters = 0, lcd_req = 0; saturation: 70 votes for cand2 -> count 63, total 63.
